// File: rtl/stream_arb_pkg.sv
// Shared definitions for the stream arbiter/mux.
//   clog2()            : ceiling log2 helper for parameter math
//   MODE_SEL / MODE_RR : selection mode encodings
//   *_MIN / *_MAX      : legal ranges for CHANNELS and WIDTH
//   state_e            : output register occupancy
package stream_arb_pkg;

  localparam int MODE_SEL  = 0;
  localparam int MODE_RR   = 1;

  localparam int CH_MIN    = 2;
  localparam int CH_MAX    = 16;
  localparam int WIDTH_MIN = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant picker.
//   req         : per-channel request vector
//   last        : most recently served channel; search starts at last+1
//   enable      : when low, no grant is issued
//   grant       : index of the winning channel
//   grant_valid : a channel was found and enable is high
module rr_arbiter #(
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last,
  input  logic                enable,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  logic w_found;
  int   w_idx;

  // Walk CHANNELS positions upward from last+1 with wrap; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 0;
    grant   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_idx = (int'(last) + k) % CHANNELS;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        grant   = SEL_W'(w_idx);
      end
    end
  end

  assign grant_valid = enable & w_found;

endmodule

// File: rtl/stream_arb_mux.sv
// N-to-1 stream multiplexer with a one-entry registered output stage.
// MODE_SEL: sel chooses the channel. MODE_RR: round-robin over valid channels.
//   clk, rst  : clock, synchronous active-high reset
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, one-hot or zero
//   sel       : channel select (MODE_SEL only)
//   out_data  : registered data of the accepted word
//   out_valid : output register holds a word
//   out_ready : downstream accepts the word
//   out_chan  : channel that supplied out_data
module stream_arb_mux
  import stream_arb_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 2,
  parameter int MODE     = MODE_SEL,
  localparam int SEL_W   = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_chan;
  logic [SEL_W-1:0] r_last;

  logic             w_load_en;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;

  // Reset also blocks loading so in_ready stays low while rst is high.
  assign w_load_en = ((r_state == ST_EMPTY) | out_ready) & ~rst;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic w_unused_sel;
      assign w_unused_sel = ^sel;

      rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
      ) u_rr (
        .req         (in_valid),
        .last        (r_last),
        .enable      (~rst),
        .grant       (w_gnt_idx),
        .grant_valid (w_gnt_vld)
      );
    end else begin : g_sel
      logic w_unused_last;
      assign w_unused_last = ^r_last;

      // Out-of-range sel simply matches no channel.
      always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
          if (sel == SEL_W'(i) && in_valid[i]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = SEL_W'(i);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++)
      in_ready[i] = w_load_en & w_gnt_vld & (w_gnt_idx == SEL_W'(i));
  end

  // Data only feeds the output register, so no in_data->output comb path.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (w_gnt_idx == SEL_W'(i)) w_sel_data = in_data[i*WIDTH +: WIDTH];
  end

  assign w_xfer = w_load_en & w_gnt_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_chan  <= '0;
      r_last  <= SEL_W'(CHANNELS - 1);
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_xfer) begin
            r_state <= ST_FULL;
            r_data  <= w_sel_data;
            r_chan  <= w_gnt_idx;
            r_last  <= w_gnt_idx;
          end
        end
        ST_FULL: begin
          if (w_xfer) begin
            r_data  <= w_sel_data;
            r_chan  <= w_gnt_idx;
            r_last  <= w_gnt_idx;
          end else if (out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_stream_arb_mux.sv
module tb_stream_arb_mux;
  localparam int W  = 8;
  localparam int C  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // MODE_SEL instance signals
  logic [C*W-1:0] sd_data;
  logic [C-1:0]   sd_valid, sd_rdy;
  logic [SW-1:0]  sd_sel, sd_chan;
  logic [W-1:0]   sd_odata;
  logic           sd_ovalid, sd_oready;
  // MODE_RR instance signals
  logic [C*W-1:0] rd_data;
  logic [C-1:0]   rd_valid, rd_rdy;
  logic [SW-1:0]  rd_sel, rd_chan;
  logic [W-1:0]   rd_odata;
  logic           rd_ovalid, rd_oready;

  stream_arb_mux #(.WIDTH(W), .CHANNELS(C), .MODE(0)) u_sel (
    .clk(clk), .rst(rst), .in_data(sd_data), .in_valid(sd_valid), .in_ready(sd_rdy),
    .sel(sd_sel), .out_data(sd_odata), .out_valid(sd_ovalid), .out_ready(sd_oready),
    .out_chan(sd_chan));

  stream_arb_mux #(.WIDTH(W), .CHANNELS(C), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(rd_data), .in_valid(rd_valid), .in_ready(rd_rdy),
    .sel(rd_sel), .out_data(rd_odata), .out_valid(rd_ovalid), .out_ready(rd_oready),
    .out_chan(rd_chan));

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: occupancy, word and source for each instance, plus RR pointer.
  logic         ms_valid, mr_valid;
  logic [W-1:0] ms_data, mr_data;
  int           ms_chan, mr_chan, m_last;

  function automatic int sel_pick(input logic [C-1:0] v, input int s);
    if (s < C && v[s]) return s;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [C-1:0] v, input int last);
    for (int k = 1; k <= C; k++)
      if (v[(last + k) % C]) return (last + k) % C;
    return -1;
  endfunction

  function automatic logic [C-1:0] exp_rdy(input int g, input logic full, input logic ordy,
                                           input logic r);
    if (r || g < 0 || (full && !ordy)) return '0;
    return C'(1) << g;
  endfunction

  function automatic logic [W-1:0] chan_word(input logic [C*W-1:0] d, input int g);
    return d[g*W +: W];
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    int gs, gr;
    logic les, ler;
    gs  = sel_pick(sd_valid, int'(sd_sel));
    gr  = rr_pick(rd_valid, m_last);
    les = !ms_valid || sd_oready;
    ler = !mr_valid || rd_oready;
    @(posedge clk);
    if (rst) begin
      ms_valid = 0; ms_data = '0; ms_chan = 0;
      mr_valid = 0; mr_data = '0; mr_chan = 0; m_last = C - 1;
    end else begin
      if (gs >= 0 && les) begin
        ms_valid = 1; ms_data = chan_word(sd_data, gs); ms_chan = gs;
      end else if (sd_oready) ms_valid = 0;
      if (gr >= 0 && ler) begin
        mr_valid = 1; mr_data = chan_word(rd_data, gr); mr_chan = gr; m_last = gr;
      end else if (rd_oready) mr_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; sd_valid = '1; rd_valid = '1; sd_oready = 1; rd_oready = 1; sd_sel = 0;
    #1;
    n_total++; if (rd_rdy !== 4'b0000) $display("FAIL rst_rdy_rr: got %b want 0000", rd_rdy); else n_pass++;
    n_total++; if (sd_rdy !== 4'b0000) $display("FAIL rst_rdy_sel: got %b want 0000", sd_rdy); else n_pass++;
    tick();
    n_total++; if ({sd_ovalid, sd_odata, sd_chan} !== '0)
      $display("FAIL rst_out_sel: got v=%b d=%h c=%0d want all 0", sd_ovalid, sd_odata, sd_chan); else n_pass++;
    n_total++; if ({rd_ovalid, rd_odata, rd_chan} !== '0)
      $display("FAIL rst_out_rr: got v=%b d=%h c=%0d want all 0", rd_ovalid, rd_odata, rd_chan); else n_pass++;
    rst = 0; sd_valid = '0; rd_valid = '0;
  endtask

  task automatic test_sel_mode();
    do_reset();
    sd_sel = 2; sd_valid = 4'b0100; sd_data = 32'h00A5_0000; sd_oready = 1;
    #1;
    n_total++; if (sd_rdy !== 4'b0100) $display("FAIL sel_rdy: got %b want 0100", sd_rdy); else n_pass++;
    tick();
    n_total++; if ({sd_ovalid, sd_odata, sd_chan} !== {1'b1, 8'hA5, 2'd2})
      $display("FAIL sel_xfer: got v=%b d=%h c=%0d want v=1 d=a5 c=2", sd_ovalid, sd_odata, sd_chan); else n_pass++;
    sd_sel = 3; sd_valid = 4'b0111;
    #1;
    n_total++; if (sd_rdy !== 4'b0000) $display("FAIL sel_novalid_rdy: got %b want 0000", sd_rdy); else n_pass++;
    tick();
    n_total++; if (sd_ovalid !== 1'b0) $display("FAIL sel_novalid_out: got %b want 0", sd_ovalid); else n_pass++;
    sd_valid = '0;
  endtask

  task automatic test_rr_sequence();
    do_reset();
    rd_valid = '1; rd_oready = 1;
    for (int i = 0; i < C; i++) rd_data[i*W +: W] = 8'h10 + 8'(i);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if ({rd_ovalid, rd_chan, rd_odata} !== {1'b1, 2'(k % C), 8'h10 + 8'(k % C)})
        $display("FAIL rr_seq%0d: got v=%b c=%0d d=%h want v=1 c=%0d", k, rd_ovalid, rd_chan, rd_odata, k % C);
      else n_pass++;
    end
    rd_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    rd_valid = 4'b0001; rd_data = 32'h0000_003C; rd_oready = 1;
    tick();
    rd_oready = 0; rd_valid = '1; rd_data = 32'h4433_2211;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (rd_rdy !== 4'b0000) $display("FAIL stall_rdy%0d: got %b want 0000", k, rd_rdy); else n_pass++;
      tick();
      n_total++; if ({rd_ovalid, rd_odata, rd_chan} !== {1'b1, 8'h3C, 2'd0})
        $display("FAIL stall_hold%0d: got v=%b d=%h c=%0d want v=1 d=3c c=0", k, rd_ovalid, rd_odata, rd_chan);
      else n_pass++;
      rd_valid = 4'(k + 6);
    end
    rd_valid = '1; rd_oready = 1;
    #1;
    n_total++; if (rd_rdy !== 4'b0010) $display("FAIL stall_release_rdy: got %b want 0010", rd_rdy); else n_pass++;
    tick();
    n_total++; if ({rd_chan, rd_odata} !== {2'd1, 8'h22})
      $display("FAIL stall_release: got c=%0d d=%h want c=1 d=22", rd_chan, rd_odata); else n_pass++;
    rd_valid = '0;
  endtask

  task automatic test_rr_skip();
    do_reset();
    rd_oready = 1; rd_valid = 4'b0010;
    tick();
    rd_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if ({rd_ovalid, rd_chan} !== {1'b1, (k == 1) ? 2'd1 : 2'd3})
        $display("FAIL rr_skip%0d: got v=%b c=%0d want c=%0d", k, rd_ovalid, rd_chan, (k == 1) ? 1 : 3);
      else n_pass++;
    end
    rd_valid = '0;
  endtask

  task automatic test_reset_mid();
    rd_valid = 4'b0100; rd_data = 32'h0077_0000; rd_oready = 1;
    sd_valid = 4'b0001; sd_sel = 0; sd_data = 32'h0000_0077; sd_oready = 1;
    tick();
    rd_oready = 0; sd_oready = 0; rst = 1;
    #1;
    n_total++; if ({rd_rdy, sd_rdy} !== 8'h00) $display("FAIL midrst_rdy: got %b %b want 0", rd_rdy, sd_rdy); else n_pass++;
    tick();
    rst = 0;
    n_total++; if ({rd_ovalid, rd_odata, rd_chan} !== '0)
      $display("FAIL midrst_rr: got v=%b d=%h c=%0d want all 0", rd_ovalid, rd_odata, rd_chan); else n_pass++;
    n_total++; if ({sd_ovalid, sd_odata, sd_chan} !== '0)
      $display("FAIL midrst_sel: got v=%b d=%h c=%0d want all 0", sd_ovalid, sd_odata, sd_chan); else n_pass++;
    rd_valid = '1; rd_oready = 1; sd_valid = '0;
    tick();
    n_total++; if ({rd_ovalid, rd_chan} !== {1'b1, 2'd0})
      $display("FAIL midrst_first: got v=%b c=%0d want v=1 c=0", rd_ovalid, rd_chan); else n_pass++;
    rd_valid = '0;
  endtask

  task automatic test_random();
    logic [C-1:0] er;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      sd_data = $urandom; rd_data = $urandom;
      sd_valid = 4'($urandom); rd_valid = 4'($urandom);
      sd_sel = 2'($urandom); rd_sel = 2'($urandom);
      sd_oready = ($urandom_range(0, 3) != 0); rd_oready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      er = exp_rdy(sel_pick(sd_valid, int'(sd_sel)), ms_valid, sd_oready, rst);
      n_total++; if (sd_rdy !== er) $display("FAIL rnd_sel_rdy@%0d: got %b want %b", cyc, sd_rdy, er); else n_pass++;
      er = exp_rdy(rr_pick(rd_valid, m_last), mr_valid, rd_oready, rst);
      n_total++; if (rd_rdy !== er) $display("FAIL rnd_rr_rdy@%0d: got %b want %b", cyc, rd_rdy, er); else n_pass++;
      tick();
      n_total++;
      if (sd_ovalid !== ms_valid || (ms_valid && {sd_odata, sd_chan} !== {ms_data, 2'(ms_chan)}))
        $display("FAIL rnd_sel_out@%0d: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                 cyc, sd_ovalid, sd_odata, sd_chan, ms_valid, ms_data, ms_chan);
      else n_pass++;
      n_total++;
      if (rd_ovalid !== mr_valid || (mr_valid && {rd_odata, rd_chan} !== {mr_data, 2'(mr_chan)}))
        $display("FAIL rnd_rr_out@%0d: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                 cyc, rd_ovalid, rd_odata, rd_chan, mr_valid, mr_data, mr_chan);
      else n_pass++;
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    sd_data = '0; sd_valid = '0; sd_sel = '0; sd_oready = 0;
    rd_data = '0; rd_valid = '0; rd_sel = '0; rd_oready = 0;
    ms_valid = 0; ms_data = '0; ms_chan = 0;
    mr_valid = 0; mr_data = '0; mr_chan = 0; m_last = C - 1;
    @(negedge clk);
    test_reset();
    test_sel_mode();
    test_rr_sequence();
    test_stall();
    test_rr_skip();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_arb_mux.md
STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

Interface
REQ-001 Parameter WIDTH, default 2: data bits per channel, >= 1.
REQ-002 Parameter CHANNELS, default 2: number of input channels, 2..16.
REQ-003 Parameter MODE, default 0: 0 = MODE_SEL (the sel port picks the channel), 1 = MODE_RR (round-robin among valid channels).
REQ-004 Derived constant SEL_W = max(1, clog2(CHANNELS)).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  per-channel valid.
REQ-009 in_ready  output  CHANNELS  per-channel ready; at most one bit set per cycle.
REQ-010 sel  input  SEL_W  channel select, used only when MODE=0.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  output holds a word.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_chan  output  SEL_W  index of the channel that supplied out_data.

Function
REQ-015 The output stage is a one-entry register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en = !out_valid | out_ready; a new word is accepted only when load_en=1.
REQ-017 In MODE=0, grant = sel when sel < CHANNELS and in_valid[sel]=1; otherwise there is no grant.
REQ-018 In MODE=0, sel >= CHANNELS never grants and leaves in_ready all zero.
REQ-019 In MODE=1, grant = the first valid channel searching upward (with wrap) from last+1, where last is the most recently accepted channel.
REQ-020 in_ready[i] = load_en & (grant == i); in_ready is all zero when no channel is granted.
REQ-021 A transfer occurs when in_valid[g] & in_ready[g]; on the next edge out_data = channel g data, out_chan = g, out_valid = 1 (latency 1 cycle).
REQ-022 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on out_ready with no transfer; FULL->FULL on out_ready with transfer (back-to-back, full throughput).
REQ-023 While out_valid=1 and out_ready=0, out_data and out_chan hold stable and in_ready is all zero.
REQ-024 The round-robin pointer last updates only on a transfer; stalls and idle cycles leave it unchanged.
REQ-025 A changing sel or in_valid while the output is stalled has no effect on the held word.
REQ-026 No combinational path exists from in_data to any output.

Reset
REQ-027 While rst=1 at a clock edge: out_valid=0, out_data=0, out_chan=0, last=CHANNELS-1 (so channel 0 wins first in MODE=1).
REQ-028 Reset asserted mid-transfer discards the held word; in_ready is all zero during every cycle rst=1.

Structure
REQ-029 Package stream_arb_pkg holds the clog2 function, MODE_SEL=0, MODE_RR=1, and the CHANNELS/WIDTH range limits.
REQ-030 Round-robin grant logic lives in sub-module rr_arbiter (inputs: req, last, enable; output: grant index, grant_valid), instantiated only when MODE=1.

Verification
REQ-031 MODE=0, CHANNELS=4, WIDTH=8, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_chan=2.
REQ-032 MODE=0, sel=3 with in_valid[3]=0 and other channels valid -> in_ready=0 and out_valid stays 0.
REQ-033 MODE=1, CHANNELS=4, all in_valid=1, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-034 Stall: out_ready=0 for 3 cycles while FULL with data 8'h3C -> out_data stays 8'h3C, in_ready=0; on release the next grant follows the pointer without skipping.
REQ-035 MODE=1, only ch1 and ch3 valid, last=1 -> grant 3, then 1, then 3.
REQ-036 rst=1 while FULL with out_ready=0 -> next cycle out_valid=0, out_data=0, out_chan=0; first MODE=1 grant after reset goes to channel 0.
